// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and memory-wait sequencing for the 5-stage ARM pipeline.
// Also keeps saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Ra1D,
  input  logic [3:0]       Ra2D,
  input  logic [3:0]       Ra1E,
  input  logic [3:0]       Ra2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReady,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             EnableE,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MEMWAIT = 2'd1;
  localparam logic [1:0] ERROR   = 2'd2;

  localparam int WW =
    (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [WW-1:0] wcnt;
  logic          ld_stall;
  logic          pc_pend;
  logic          err;
  logic          freeze;
  logic          wait_hit;

  // RegWriteE only matters through MemtoRegE; kept for port completeness.
  logic unused_ok;
  assign unused_ok = RegWriteE;

  // Operand forwarding: Memory stage result wins over Writeback.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (Ra1E == WA3M))
      ForwardAE = 2'b10;
    else if (RegWriteW && (Ra1E == WA3W))
      ForwardAE = 2'b01;
    if (RegWriteM && (Ra2E == WA3M))
      ForwardBE = 2'b10;
    else if (RegWriteW && (Ra2E == WA3W))
      ForwardBE = 2'b01;
  end

  assign ld_stall = MemtoRegE &
                    ((Ra1D == WA3E) | (Ra2D == WA3E));
  assign pc_pend  = PCSrcD | PCSrcE | PCSrcM;
  assign wait_hit = (wcnt == WW'(WAIT_TIMEOUT));

  // Freeze starts combinationally on the entry cycle; reset forces RUN view.
  always_comb begin
    err    = ~reset & (state == ERROR);
    freeze = err;
    if (!reset) begin
      if (state == RUN && MemReqM && !MemReady)
        freeze = 1'b1;
      if (state == MEMWAIT && !MemReady)
        freeze = 1'b1;
    end
  end

  // Stall/flush outputs: frozen pipeline or normal hazard equations.
  always_comb begin
    if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end else begin
      StallF = ld_stall | pc_pend;
      StallD = ld_stall;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = pc_pend | PCSrcW | BranchTakenE;
      FlushE = ld_stall | BranchTakenE;
      FlushW = 1'b0;
    end
    EnableE    = ~StallE;
    MemTimeout = err;
  end

  // Next-state selection for the memory-wait sequencer.
  always_comb begin
    state_n = state;
    unique case (state)
      RUN: begin
        if (MemReqM && !MemReady)
          state_n = MEMWAIT;
      end
      MEMWAIT: begin
        if (MemReady)
          state_n = RUN;
        else if (wait_hit)
          state_n = ERROR;
      end
      ERROR:   state_n = ERROR;
      default: state_n = RUN;
    endcase
  end

  // State register and wait-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      if (state == MEMWAIT && !MemReady)
        wcnt <= wcnt + 1'b1;
      else
        wcnt <= '0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && (StallCount != '1))
        StallCount <= StallCount + 1'b1;
      if ((FlushD || FlushE) && (FlushCount != '1))
        FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipelined ARM core (F/D/E/M/W).
- Drives the stall, flush and enable inputs of every inter-stage pipeline register, including the Decode→Execute control register.
- Generates the ALU operand forwarding selects.
- Holds the whole pipeline through multi-cycle data-memory accesses with a ready handshake, and keeps saturating stall/flush performance counters.

Parameters:
WAIT_TIMEOUT, 255, max consecutive MEMWAIT cycles before entering ERROR
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
Ra1D, Ra2D  in  4  source regs in Decode
Ra1E, Ra2E  in  4  source regs in Execute
WA3E, WA3M, WA3W  in  4  destination regs in E/M/W
RegWriteE, RegWriteM, RegWriteW  in  1  reg-write enables per stage
MemtoRegE  in  1  load in Execute
PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  PC write pending per stage
BranchTakenE  in  1  branch resolved taken in Execute
MemReqM  in  1  Memory stage is doing a load/store
MemReady  in  1  data memory completes access this cycle
ForwardAE, ForwardBE  out  2  00 regfile, 01 ResultW, 10 ALUResultM
StallF, StallD, StallE, StallM  out  1  hold stage register
FlushD, FlushE, FlushW  out  1  clear stage register to bubble
EnableE  out  1  we of the D→E control register (= ~StallE)
MemTimeout  out  1  sticky error flag
StallCount, FlushCount  out  CNT_W  saturating event counters

Behaviour:
FSM states: RUN, MEMWAIT, ERROR. Reset → RUN, counters 0, MemTimeout 0.

Forwarding (combinational, all states):
- ForwardAE=10 if RegWriteM & Ra1E==WA3M.
- Else ForwardAE=01 if RegWriteW & Ra1E==WA3W.
- Else ForwardAE=00.
- M has priority over W. ForwardBE uses the same rule with Ra2E.

Hazard terms:
- LdStall = MemtoRegE & ((Ra1D==WA3E)|(Ra2D==WA3E)).
- PCPend = PCSrcD|PCSrcE|PCSrcM.

RUN outputs:
- StallF = LdStall|PCPend.
- StallD = LdStall.
- StallE = StallM = 0.
- FlushD = PCPend|PCSrcW|BranchTakenE.
- FlushE = LdStall|BranchTakenE.
- FlushW = 0.

RUN transition:
- If MemReqM & ~MemReady: go to MEMWAIT next cycle.
- In that same cycle outputs are already the MEMWAIT values (the freeze is combinational on the entry condition, not delayed).

MEMWAIT / freeze (also applies to the RUN entry cycle):
- StallF=StallD=StallE=StallM=1; FlushD=FlushE=0; FlushW=1 (bubble into W).
- Hazard-derived flushes are suppressed; they re-evaluate on release because the inputs are held.
- Cycle counter wcnt increments each MEMWAIT cycle.
- MemReady=1 → outputs revert to the RUN equations that same cycle; next state RUN; wcnt cleared.
- wcnt==WAIT_TIMEOUT with MemReady=0 → ERROR.

ERROR:
- All stalls 1, all flushes 0, FlushW=1, MemTimeout=1.
- Left only by reset.

EnableE = ~StallE in all states.

Counters (saturate at all-ones, never wrap):
- StallCount increments every cycle StallF=1.
- FlushCount increments every cycle FlushD|FlushE=1.

Reset behaviour:
- Reset during MEMWAIT or ERROR returns to RUN next edge.
- While reset=1, outputs are the RUN equations.

Test Plan:
- Forwarding priority: RegWriteM=RegWriteW=1, WA3M=WA3W=Ra1E=3 → ForwardAE=10; deassert RegWriteM → 01; Ra1E=4 → 00.
- Load-use hazard: MemtoRegE=1, WA3E=5, Ra2D=5 → StallF=StallD=FlushE=1 for exactly one cycle; StallCount +1, FlushCount +1.
- Branch taken: BranchTakenE=1 → FlushD=FlushE=1, StallF=0; PCSrcD=1 then PCSrcE, PCSrcM, PCSrcW on successive cycles → StallF=1 for 3 cycles, FlushD=1 for 4 cycles.
- Memory wait: MemReqM=1, MemReady=0 for 3 cycles, then 1 → all stalls and FlushW=1 for 3 cycles, EnableE=0; a concurrent BranchTakenE flush is suppressed during the wait and asserted on the release cycle.
- Timeout: WAIT_TIMEOUT=4, MemReady held 0 → MemTimeout=1 after the 5th wait cycle and stays set; reset → RUN, MemTimeout=0, counters 0.
- Saturation: CNT_W=4, continuous LdStall for 20 cycles → StallCount=15 and holds.
